// File: rtl/apu_bus_responder_if.sv
// CPU-bus and register-file signal bundle for the APU bus responder.
// The slave modport is the responder; the master modport is the CPU/pad plus register-file side.
interface apu_bus_responder_if;
  logic        M2;
  logic        RnW;
  logic [15:0] A;
  logic [7:0]  D_in;
  logic [7:0]  D_out;
  logic        D_oe;
  logic [4:0]  reg_sel;
  logic        reg_rd;
  logic        reg_wr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        bus_err;
  logic        clr_err;

  modport slave (
    input  M2, RnW, A, D_in, reg_rdata, clr_err,
    output D_out, D_oe, reg_sel, reg_rd, reg_wr, reg_wdata, bus_err
  );

  modport master (
    output M2, RnW, A, D_in, reg_rdata, clr_err,
    input  D_out, D_oe, reg_sel, reg_rd, reg_wr, reg_wdata, bus_err
  );
endinterface

// File: rtl/apu_bus_responder.sv
// APU register-file bus target: synchronizes M2, decodes the register window, issues
// single-cycle read/write strobes, drives read data while M2 is high, and aborts stuck cycles.
module apu_bus_responder #(
  parameter logic [15:0] BASE_ADDR   = 16'h4000,
  parameter logic [15:0] ADDR_MASK   = 16'hFFE0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 24
) (
  input logic                CLK,
  input logic                n_RES,
  apu_bus_responder_if.slave bus
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdDrive,
    StWrWait,
    StMiss,
    StAbort
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] vld_q;
  logic                   m2_d_q;
  logic                   armed_q, armed_d;
  logic [CntW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [4:0]             reg_sel_q, reg_sel_d;
  logic [7:0]             d_out_q, d_out_d;
  logic [7:0]             wdata_q, wdata_d;
  logic                   reg_wr_q, reg_wr_d;
  logic                   bus_err_q, bus_err_d;

  logic m2_s, rise, fall, hit, active, tmo;

  assign m2_s = sync_q[SYNC_STAGES-1];

  // Edges only count once a real low M2 has been seen after reset, so releasing reset
  // with M2 already high cannot fake a rise.
  assign armed_d = armed_q | (vld_q[SYNC_STAGES-1] & ~m2_s);
  assign rise    = armed_q & m2_s & ~m2_d_q;
  assign fall    = armed_q & ~m2_s & m2_d_q;

  assign hit     = ((bus.A & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
  assign active  = state_q inside {StRdReq, StRdDrive, StWrWait, StMiss};
  assign cnt_inc = cnt_q + 1'b1;
  assign tmo     = active & (cnt_inc == CntW'(TIMEOUT));

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      state_q   <= StIdle;
      sync_q    <= '0;
      vld_q     <= '0;
      m2_d_q    <= 1'b0;
      armed_q   <= 1'b0;
      cnt_q     <= '0;
      reg_sel_q <= '0;
      d_out_q   <= '0;
      wdata_q   <= '0;
      reg_wr_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[SYNC_STAGES-2:0], bus.M2};
      vld_q     <= {vld_q[SYNC_STAGES-2:0], 1'b1};
      m2_d_q    <= m2_s;
      armed_q   <= armed_d;
      cnt_q     <= cnt_d;
      reg_sel_q <= reg_sel_d;
      d_out_q   <= d_out_d;
      wdata_q   <= wdata_d;
      reg_wr_q  <= reg_wr_d;
      bus_err_q <= bus_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = active ? cnt_inc : cnt_q;
    reg_sel_d = reg_sel_q;
    d_out_d   = d_out_q;
    wdata_d   = wdata_q;
    reg_wr_d  = 1'b0;
    bus_err_d = bus.clr_err ? 1'b0 : bus_err_q;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          cnt_d     = '0;
          reg_sel_d = bus.A[4:0];
          if (!hit) begin
            state_d = StMiss;
          end else if (bus.RnW) begin
            state_d = StRdReq;
          end else begin
            state_d = StWrWait;
          end
        end
      end
      StRdReq: begin
        // Register file answers by the end of the strobe cycle.
        d_out_d = bus.reg_rdata;
        state_d = fall ? StIdle : StRdDrive;
      end
      StRdDrive: begin
        if (fall) state_d = StIdle;
      end
      StWrWait: begin
        if (fall) begin
          wdata_d  = bus.D_in;
          reg_wr_d = 1'b1;
          state_d  = StIdle;
        end
      end
      StMiss: begin
        if (fall) state_d = StIdle;
      end
      StAbort: begin
        if (!m2_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A completed cycle wins over a timeout landing on the same edge; set beats clear.
    if (tmo && (state_d != StIdle)) begin
      state_d   = StAbort;
      reg_wr_d  = 1'b0;
      bus_err_d = 1'b1;
    end
  end

  assign bus.D_out     = d_out_q;
  assign bus.D_oe      = (state_q == StRdDrive);
  assign bus.reg_sel   = reg_sel_q;
  assign bus.reg_rd    = (state_q == StRdReq);
  assign bus.reg_wr    = reg_wr_q;
  assign bus.reg_wdata = wdata_q;
  assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_apu_bus_responder.sv
// Directed bench for apu_bus_responder: strobes are scored against a queue of expected
// accesses; timing-specific behaviour is checked inline.
module tb_apu_bus_responder;

  typedef struct packed {
    logic       wr;
    logic [4:0] sel;
    logic [7:0] data;
  } exp_t;

  logic CLK;
  logic n_RES;
  apu_bus_responder_if bus ();

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic       rd_pend = 1'b0;
  logic [7:0] rd_exp  = 8'h00;

  apu_bus_responder dut (
    .CLK   (CLK),
    .n_RES (n_RES),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Scoreboard side: every strobe must match the oldest outstanding expected access.
  always @(negedge CLK) begin
    exp_t e;
    if (rd_pend) begin
      rd_pend = 1'b0;
      chk("rd_drive_oe", 32'(bus.D_oe), 32'd1);
      chk("rd_drive_data", 32'(bus.D_out), 32'(rd_exp));
    end
    if (bus.reg_rd || bus.reg_wr) begin
      chk("strobe_excl", 32'(bus.reg_rd & bus.reg_wr), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'({bus.reg_rd, bus.reg_wr}), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("strobe_kind", 32'(bus.reg_wr), 32'(e.wr));
        chk("strobe_sel", 32'(bus.reg_sel), 32'(e.sel));
        if (e.wr) begin
          chk("strobe_wdata", 32'(bus.reg_wdata), 32'(e.data));
        end else begin
          rd_pend = 1'b1;
          rd_exp  = e.data;
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_RES         = 1'b0;
    bus.M2        = 1'b0;
    bus.RnW       = 1'b1;
    bus.A         = 16'h0000;
    bus.D_in      = 8'h00;
    bus.reg_rdata = 8'h00;
    bus.clr_err   = 1'b0;
    #1;
    chk("rst_d_oe", 32'(bus.D_oe), 32'd0);
    chk("rst_d_out", 32'(bus.D_out), 32'd0);
    chk("rst_reg_sel", 32'(bus.reg_sel), 32'd0);
    chk("rst_strobes", 32'({bus.reg_rd, bus.reg_wr}), 32'd0);
    chk("rst_bus_err", 32'(bus.bus_err), 32'd0);
    repeat (3) tick();
    n_RES = 1'b1;
    repeat (5) tick();

    // Read hit
    bus.A = 16'h4015; bus.RnW = 1'b1; bus.reg_rdata = 8'hA5;
    sb.push_back(exp_t'{1'b0, 5'h15, 8'hA5});
    bus.M2 = 1'b1;
    repeat (3) tick();
    chk("rd_strobe_k1", 32'(bus.reg_rd), 32'd1);
    chk("rd_sel", 32'(bus.reg_sel), 32'h15);
    chk("rd_oe_k1", 32'(bus.D_oe), 32'd0);
    tick();
    chk("rd_single", 32'(bus.reg_rd), 32'd0);
    chk("rd_oe_k2", 32'(bus.D_oe), 32'd1);
    chk("rd_data_k2", 32'(bus.D_out), 32'hA5);
    repeat (8) tick();
    bus.M2 = 1'b0;
    repeat (2) tick();
    chk("rd_oe_fall", 32'(bus.D_oe), 32'd1);
    tick();
    chk("rd_oe_off", 32'(bus.D_oe), 32'd0);
    repeat (2) tick();

    // Write hit
    bus.A = 16'h4003; bus.RnW = 1'b0; bus.D_in = 8'h7C;
    sb.push_back(exp_t'{1'b1, 5'h03, 8'h7C});
    bus.M2 = 1'b1;
    repeat (5) tick();
    chk("wr_none_high", 32'(bus.reg_wr), 32'd0);
    repeat (3) tick();
    bus.M2 = 1'b0;
    repeat (2) tick();
    chk("wr_none_fall", 32'(bus.reg_wr), 32'd0);
    tick();
    chk("wr_strobe", 32'(bus.reg_wr), 32'd1);
    chk("wr_wdata", 32'(bus.reg_wdata), 32'h7C);
    chk("wr_sel", 32'(bus.reg_sel), 32'h03);
    tick();
    chk("wr_single", 32'(bus.reg_wr), 32'd0);
    chk("wr_wdata_held", 32'(bus.reg_wdata), 32'h7C);
    repeat (2) tick();

    // Miss, read then write
    for (int i = 0; i < 2; i++) begin
      bus.A = 16'h2002; bus.RnW = (i == 0); bus.D_in = 8'h99;
      bus.M2 = 1'b1;
      repeat (5) tick();
      chk("miss_oe", 32'(bus.D_oe), 32'd0);
      chk("miss_strobes", 32'({bus.reg_rd, bus.reg_wr}), 32'd0);
      bus.M2 = 1'b0;
      repeat (4) tick();
      chk("miss_strobes_after", 32'({bus.reg_rd, bus.reg_wr}), 32'd0);
    end

    // Timeout on a write held high for 40 CLK
    bus.A = 16'h4000; bus.RnW = 1'b0; bus.D_in = 8'hEE;
    bus.M2 = 1'b1;
    repeat (26) tick();
    chk("tmo_not_yet", 32'(bus.bus_err), 32'd0);
    tick();
    chk("tmo_err", 32'(bus.bus_err), 32'd1);
    chk("tmo_oe", 32'(bus.D_oe), 32'd0);
    repeat (13) tick();
    bus.M2 = 1'b0;
    repeat (4) tick();
    chk("tmo_no_wr", 32'(bus.reg_wr), 32'd0);
    chk("tmo_sticky", 32'(bus.bus_err), 32'd1);
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    chk("tmo_clr", 32'(bus.bus_err), 32'd0);
    bus.A = 16'h4001; bus.D_in = 8'h11;
    sb.push_back(exp_t'{1'b1, 5'h01, 8'h11});
    bus.M2 = 1'b1;
    repeat (6) tick();
    bus.M2 = 1'b0;
    repeat (3) tick();
    chk("post_tmo_wr", 32'(bus.reg_wr), 32'd1);
    repeat (2) tick();

    // Async reset during read drive, released while M2 is still high
    bus.A = 16'h4008; bus.RnW = 1'b1; bus.reg_rdata = 8'h3C;
    sb.push_back(exp_t'{1'b0, 5'h08, 8'h3C});
    bus.M2 = 1'b1;
    repeat (5) tick();
    chk("rst_pre_oe", 32'(bus.D_oe), 32'd1);
    #2;
    n_RES = 1'b0;
    #1;
    chk("arst_oe", 32'(bus.D_oe), 32'd0);
    chk("arst_d_out", 32'(bus.D_out), 32'd0);
    chk("arst_sel", 32'(bus.reg_sel), 32'd0);
    chk("arst_strobes", 32'({bus.reg_rd, bus.reg_wr}), 32'd0);
    repeat (2) tick();
    n_RES = 1'b1;
    repeat (10) tick();
    chk("arst_no_strobe", 32'(bus.reg_rd), 32'd0);
    chk("arst_no_oe", 32'(bus.D_oe), 32'd0);
    bus.M2 = 1'b0;
    repeat (4) tick();

    // Back-to-back write then read with one low CLK between
    bus.A = 16'h4010; bus.RnW = 1'b0; bus.D_in = 8'h5A; bus.reg_rdata = 8'hC3;
    sb.push_back(exp_t'{1'b1, 5'h10, 8'h5A});
    sb.push_back(exp_t'{1'b0, 5'h11, 8'hC3});
    bus.M2 = 1'b1;
    repeat (8) tick();
    bus.M2 = 1'b0;
    bus.A = 16'h4011; bus.RnW = 1'b1;
    tick();
    bus.M2 = 1'b1;
    repeat (8) tick();
    bus.M2 = 1'b0;
    repeat (5) tick();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("final_bus_err", 32'(bus.bus_err), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
